digit_scan_mux: RTL and testbench

- Parametrised time-multiplexed scanner for common-anode multi-digit displays.
- Cycles through NUM_DIGITS digit slots at a rate set by an internal prescaler, driving one digit's data onto a shared segment/code bus with a matching active-low digit enable.
- Adds per-digit blanking, PWM brightness, a run/hold enable and a frame-start strobe.
- Sits between the display data registers and the board pins in the display subsystem.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 41 ++++
 rtl/digit_scan_mux.sv | 127 ++++++++++++
 tb/tb_digit_scan_mux.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed display scanner: the one-cold
// digit-enable encoder and the parameter legality check used at elaboration.
package disp_pkg;

    // Widest display the scanner supports; encoder results are this wide.
    localparam int MAX_DIGITS = 16;

    // Active-low one-cold enable: bits below n are high except bit d.
    // Bits at or above n are returned low and are sliced off by the caller.
    function automatic logic [MAX_DIGITS-1:0] digit_en_n(input int d, input int n);
        logic [MAX_DIGITS-1:0] v;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            v[k] = (k < n) && (k != d);
        end
        return v;
    endfunction

    // True when the parameter set describes a buildable scanner.
    // Slot length must split evenly into 2**bw brightness steps.
    function automatic bit params_legal(input int n, input int dw, input int p, input int bw);
        return (n >= 2) && (n <= MAX_DIGITS) && (dw >= 1) &&
               (bw >= 1) && (bw < 16) &&
               (p >= (1 << bw)) && ((p % (1 << bw)) == 0);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for the display scanner: counts PRESCALE clocks per digit slot,
// freezes while the scan is held, and flags the slot boundary.
module scan_prescaler
    import disp_pkg::*;
#(
    parameter int PRESCALE = 64,
    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PRE_W-1:0] pre_cnt,
    output logic             tick,
    output logic             slot_start
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("scan_prescaler: PRESCALE must be at least 2");
    end

    // Free-running slot counter, wrapping at PRESCALE-1; holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // tick marks the last clock of a running slot; the digit index advances on it.
    assign tick       = en && (pre_cnt == LAST);
    // slot_start is true during the first clock of every slot.
    assign slot_start = (pre_cnt == '0);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit display.
// Walks digit slots from the most significant digit down, driving that
// digit's code and its active-low enable, with per-slot PWM brightness,
// per-digit blanking, a run/hold input and a frame-start strobe.
//
// All three outputs are registered from the current scan state, so they
// trail the internal counters by one clock. din is not captured per slot:
// a code change is visible on dout one clock later.
module digit_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 6,
    parameter int PRESCALE   = 64,
    parameter int BRIGHT_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_DIGITS*DATA_W-1:0] din,
    input  logic [NUM_DIGITS-1:0]        blank,
    input  logic [BRIGHT_W-1:0]          bright,
    output logic [DATA_W-1:0]            dout,
    output logic [NUM_DIGITS-1:0]        eout,
    output logic                         frame_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    // On-time width leaves one spare bit so (lvl+1)*step never wraps.
    localparam int T_W   = BRIGHT_W + PRE_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [T_W-1:0]   STEP     = T_W'(PRESCALE >> BRIGHT_W);

    if (!params_legal(NUM_DIGITS, DATA_W, PRESCALE, BRIGHT_W)) begin : g_bad_params
        $error("digit_scan_mux: illegal NUM_DIGITS/DATA_W/PRESCALE/BRIGHT_W combination");
    end

    logic [PRE_W-1:0]      pre_cnt;
    logic                  tick;
    logic                  slot_start;
    logic [IDX_W-1:0]      idx;
    logic [BRIGHT_W-1:0]   lvl;

    logic [IDX_W-1:0]      dsel;
    logic [BRIGHT_W-1:0]   lvl_eff;
    logic [T_W-1:0]        on_time;
    logic                  on_active;
    logic [DATA_W-1:0]     cur_code;
    logic                  cur_blank;
    logic [MAX_DIGITS-1:0] en_full;
    logic [NUM_DIGITS-1:0] on_n;
    logic                  unused_en_bits;

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pre_cnt    (pre_cnt),
        .tick       (tick),
        .slot_start (slot_start)
    );

    // Digit index: advance on every slot tick, wrap after the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Brightness latch: sample bright at the first clock of each running slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= '0;
        end else if (en && slot_start) begin
            lvl <= bright;
        end
    end

    // Scan decode: pick the driven digit, its code and blank bit, and
    // decide whether the PWM window is still open at this point of the slot.
    always_comb begin
        dsel      = LAST_IDX - idx;
        cur_code  = '0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dsel == IDX_W'(k)) begin
                cur_code  = din[k*DATA_W +: DATA_W];
                cur_blank = blank[k];
            end
        end
        // The latch loads on the slot's first clock, so use bright directly
        // there; the whole slot then runs with one consistent level.
        lvl_eff   = slot_start ? bright : lvl;
        on_time   = ({{(T_W-BRIGHT_W){1'b0}}, lvl_eff} + T_W'(1)) * STEP;
        on_active = ({{(T_W-PRE_W){1'b0}}, pre_cnt} < on_time);
        en_full   = digit_en_n(int'(dsel), NUM_DIGITS);
        on_n      = en_full[NUM_DIGITS-1:0];
    end

    // The encoder is fixed-width; only the low NUM_DIGITS bits are driven out.
    assign unused_en_bits = ^en_full;

    // Output registers: dark and cleared on reset or hold, otherwise the
    // current digit with its enable gated by blanking and the PWM window.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            dout        <= '0;
            eout        <= '1;
            frame_start <= 1'b0;
        end else begin
            dout        <= cur_code;
            eout        <= (cur_blank || !on_active) ? '1 : on_n;
            frame_start <= tick && (idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: two instances (default build and an 8-digit,
// 8-clock-slot build) checked cycle by cycle against a position-based model.
module tb_digit_scan_mux;

    localparam int A_N = 6, A_DW = 6, A_P = 64, A_BW = 2;
    localparam int B_N = 8, B_DW = 4, B_P = 8,  B_BW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_a, en_a;
    logic [A_N*A_DW-1:0]  din_a;
    logic [A_N-1:0]       blank_a;
    logic [A_BW-1:0]      bright_a;
    logic [A_DW-1:0]      dout_a;
    logic [A_N-1:0]       eout_a;
    logic                 fs_a;

    logic                 rst_b, en_b;
    logic [B_N*B_DW-1:0]  din_b;
    logic [B_N-1:0]       blank_b;
    logic [B_BW-1:0]      bright_b;
    logic [B_DW-1:0]      dout_b;
    logic [B_N-1:0]       eout_b;
    logic                 fs_b;

    digit_scan_mux #(.NUM_DIGITS(A_N), .DATA_W(A_DW), .PRESCALE(A_P), .BRIGHT_W(A_BW)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .blank(blank_a), .bright(bright_a),
        .dout(dout_a), .eout(eout_a), .frame_start(fs_a)
    );

    digit_scan_mux #(.NUM_DIGITS(B_N), .DATA_W(B_DW), .PRESCALE(B_P), .BRIGHT_W(B_BW)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .blank(blank_b), .bright(bright_b),
        .dout(dout_b), .eout(eout_b), .frame_start(fs_b)
    );

    int checks = 0;
    int passed = 0;

    // Model state: enabled clocks since reset (mod one frame) and the level
    // captured at the start of the current slot.
    int run_a = 0, lvl_a = 0, run_b = 0, lvl_b = 0;
    logic [15:0] exp_e_a, exp_d_a, exp_e_b, exp_d_b;
    logic        exp_f_a, exp_f_b;

    // Expected outputs for a running scanner at frame position pos.
    function automatic void model_out(input int n, input int dw, input int p, input int bw,
                                      input int pos, input int held,
                                      input logic [63:0] din, input logic [15:0] blank,
                                      input int bright,
                                      output logic [15:0] e, output logic [15:0] dv,
                                      output logic f);
        int slot, off, d, level, t;
        logic [15:0] ones;
        ones  = 16'((32'd1 << n) - 1);
        slot  = pos / p;
        off   = pos % p;
        d     = n - 1 - slot;
        level = (off == 0) ? bright : held;
        t     = (level + 1) * (p / (1 << bw));
        dv    = 16'((din >> (d * dw)) & ((64'd1 << dw) - 1));
        if (blank[d] || off >= t) e = ones;
        else                      e = ones & ~(16'd1 << d);
        f = (pos == n * p - 1);
    endfunction

    // One clock: predict both instances from the inputs about to be sampled,
    // advance the models, then settle just past the edge.
    task automatic cycle();
        if (rst_a) begin
            exp_e_a = 16'h003F; exp_d_a = '0; exp_f_a = 1'b0; run_a = 0; lvl_a = 0;
        end else if (!en_a) begin
            exp_e_a = 16'h003F; exp_d_a = '0; exp_f_a = 1'b0;
        end else begin
            model_out(A_N, A_DW, A_P, A_BW, run_a, lvl_a, {28'h0, din_a}, {10'h0, blank_a},
                      int'(bright_a), exp_e_a, exp_d_a, exp_f_a);
            if (run_a % A_P == 0) lvl_a = int'(bright_a);
            run_a = (run_a + 1) % (A_N * A_P);
        end
        if (rst_b) begin
            exp_e_b = 16'h00FF; exp_d_b = '0; exp_f_b = 1'b0; run_b = 0; lvl_b = 0;
        end else if (!en_b) begin
            exp_e_b = 16'h00FF; exp_d_b = '0; exp_f_b = 1'b0;
        end else begin
            model_out(B_N, B_DW, B_P, B_BW, run_b, lvl_b, {32'h0, din_b}, {8'h0, blank_b},
                      int'(bright_b), exp_e_b, exp_d_b, exp_f_b);
            if (run_b % B_P == 0) lvl_b = int'(bright_b);
            run_b = (run_b + 1) % (B_N * B_P);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1; bright_a = 2'd3;
        rst_b = 1'b1; en_b = 1'b1; bright_b = 3'd0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                $display("FAIL reset_a: got fs=%b eout=%b dout=%0d, need fs=%b eout=%b dout=%0d",
                         fs_a, eout_a, dout_a, exp_f_a, exp_e_a[5:0], exp_d_a[5:0]);
            else passed++;
            checks++;
            if ({fs_b, eout_b, dout_b} !== {1'b0, 8'hFF, 4'h0})
                $display("FAIL reset_b: got fs=%b eout=%b dout=%0d, need fs=0 eout=11111111 dout=0",
                         fs_b, eout_b, dout_b);
            else passed++;
        end
    endtask

    task automatic test_scan_order();
        logic [5:0] seq_e [6] = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
        int pulses = 0;
        din_a = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
        blank_a = '0; bright_a = 2'd3; en_a = 1'b1;
        reset_a();
        for (int i = 0; i < 2 * A_N * A_P; i++) begin
            cycle();
            if (fs_a === 1'b1) pulses++;
            checks++;
            if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                $display("FAIL scan_order cyc %0d: got fs=%b eout=%b dout=%0d, need fs=%b eout=%b dout=%0d",
                         i, fs_a, eout_a, dout_a, exp_f_a, exp_e_a[5:0], exp_d_a[5:0]);
            else passed++;
            if (i % A_P == 0) begin
                checks++;
                if (eout_a !== seq_e[(i / A_P) % A_N] || dout_a !== 6'(A_N - (i / A_P) % A_N))
                    $display("FAIL slot_code cyc %0d: got eout=%b dout=%0d, need eout=%b dout=%0d",
                             i, eout_a, dout_a, seq_e[(i / A_P) % A_N], A_N - (i / A_P) % A_N);
                else passed++;
            end
        end
        checks++;
        if (pulses !== 2) $display("FAIL frame_pulses: got %0d, need 2", pulses);
        else passed++;
    endtask

    task automatic test_brightness();
        int on_cnt;
        int need [3] = '{16, 16, 32};
        blank_a = '0; bright_a = 2'd0; en_a = 1'b1;
        reset_a();
        for (int w = 0; w < 3; w++) begin
            on_cnt = 0;
            for (int i = 0; i < A_P; i++) begin
                if (w == 1 && i == 10) bright_a = 2'd1;
                cycle();
                if (eout_a !== 6'h3F) on_cnt++;
                checks++;
                if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                    $display("FAIL brightness cyc %0d/%0d: got eout=%b dout=%0d, need eout=%b dout=%0d",
                             w, i, eout_a, dout_a, exp_e_a[5:0], exp_d_a[5:0]);
                else passed++;
            end
            checks++;
            if (on_cnt !== need[w]) $display("FAIL on_time slot %0d: got %0d, need %0d", w, on_cnt, need[w]);
            else passed++;
        end
    endtask

    task automatic test_blanking();
        int dark = 0;
        blank_a = 6'b000100; bright_a = 2'd3; en_a = 1'b1;
        reset_a();
        for (int i = 0; i < A_N * A_P; i++) begin
            cycle();
            if (eout_a === 6'h3F) dark++;
            checks++;
            if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                $display("FAIL blanking cyc %0d: got eout=%b dout=%0d, need eout=%b dout=%0d",
                         i, eout_a, dout_a, exp_e_a[5:0], exp_d_a[5:0]);
            else passed++;
        end
        checks++;
        if (dark !== A_P) $display("FAIL blank_dark: got %0d dark cycles, need %0d", dark, A_P);
        else passed++;
        blank_a = '0;
    endtask

    task automatic test_hold();
        int d3 = 0;
        bright_a = 2'd3; blank_a = '0; en_a = 1'b1;
        din_a = {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
        reset_a();
        for (int i = 0; i < 2 * A_P + 20; i++) cycle();
        en_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            checks++;
            if ({fs_a, eout_a, dout_a} !== {1'b0, 6'h3F, 6'h00})
                $display("FAIL hold cyc %0d: got fs=%b eout=%b dout=%0d, need fs=0 eout=111111 dout=0",
                         i, fs_a, eout_a, dout_a);
            else passed++;
        end
        en_a = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (eout_a === 6'b110111) d3++;
            checks++;
            if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                $display("FAIL resume cyc %0d: got eout=%b dout=%0d, need eout=%b dout=%0d",
                         i, eout_a, dout_a, exp_e_a[5:0], exp_d_a[5:0]);
            else passed++;
        end
        checks++;
        if (d3 !== 44) $display("FAIL resume_remaining: got %0d, need 44", d3);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int d5 = 0;
        bright_a = 2'd3; blank_a = '0; en_a = 1'b1;
        reset_a();
        for (int i = 0; i < 4 * A_P + 30; i++) cycle();
        reset_a();
        checks++;
        if ({fs_a, eout_a, dout_a} !== {1'b0, 6'h3F, 6'h00})
            $display("FAIL reset_mid: got fs=%b eout=%b dout=%0d, need fs=0 eout=111111 dout=0",
                     fs_a, eout_a, dout_a);
        else passed++;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (eout_a === 6'b011111) d5++;
        end
        checks++;
        if (d5 !== A_P) $display("FAIL restart_slot: got %0d, need %0d", d5, A_P);
        else passed++;
    endtask

    task automatic test_random();
        en_a = 1'b1;
        reset_a();
        for (int i = 0; i < 3000; i++) begin
            din_a = {4'($urandom), $urandom};
            if ($urandom_range(0, 40) == 0) bright_a = 2'($urandom);
            if ($urandom_range(0, 200) == 0) blank_a = 6'($urandom);
            en_a  = ($urandom_range(0, 15) != 0);
            rst_a = ($urandom_range(0, 499) == 0);
            cycle();
            checks++;
            if ({fs_a, eout_a, dout_a} !== {exp_f_a, exp_e_a[5:0], exp_d_a[5:0]})
                $display("FAIL random cyc %0d: got fs=%b eout=%b dout=%0d, need fs=%b eout=%b dout=%0d",
                         i, fs_a, eout_a, dout_a, exp_f_a, exp_e_a[5:0], exp_d_a[5:0]);
            else passed++;
        end
        rst_a = 1'b1;
    endtask

    task automatic test_small_build();
        int on_cnt = 0;
        logic [7:0] seen = '0;
        rst_a = 1'b1;
        en_b = 1'b1; bright_b = 3'd0; blank_b = '0; din_b = $urandom;
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        for (int i = 0; i < B_N * B_P; i++) begin
            cycle();
            if (eout_b !== 8'hFF) begin
                on_cnt++;
                seen = seen | ~eout_b;
                checks++;
                if ($countones(~eout_b) != 1) $display("FAIL one_cold_b: got eout=%b", eout_b);
                else passed++;
            end
        end
        checks++;
        if (on_cnt !== B_N || seen !== 8'hFF)
            $display("FAIL small_codes: got on=%0d seen=%b, need on=8 seen=11111111", on_cnt, seen);
        else passed++;
        for (int i = 0; i < 300; i++) begin
            din_b = $urandom;
            if ($urandom_range(0, 10) == 0) bright_b = 3'($urandom);
            blank_b = ($urandom_range(0, 20) == 0) ? 8'($urandom) : 8'h00;
            en_b = ($urandom_range(0, 9) != 0);
            cycle();
            checks++;
            if ({fs_b, eout_b, dout_b} !== {exp_f_b, exp_e_b[7:0], exp_d_b[3:0]})
                $display("FAIL small_random cyc %0d: got fs=%b eout=%b dout=%0d, need fs=%b eout=%b dout=%0d",
                         i, fs_b, eout_b, dout_b, exp_f_b, exp_e_b[7:0], exp_d_b[3:0]);
            else passed++;
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; din_a = '0; blank_a = '0; bright_a = '0;
        rst_b = 1'b1; en_b = 1'b0; din_b = '0; blank_b = '0; bright_b = '0;
        test_reset();
        test_scan_order();
        test_brightness();
        test_blanking();
        test_hold();
        test_reset_mid();
        test_random();
        test_small_build();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
